mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 30 +++
 rtl/mem_arbiter.sv | 115 +++++++++++
 tb/tb_mem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - cache-side request/response and RAM-side strobe bundle for mem_arbiter
// slave is the arbiter's view; master is the caches-plus-RAM environment.
interface mem_arbiter_if;
  logic [1:0]       iREN;
  logic [1:0][31:0] iaddr;
  logic [1:0]       iwait;
  logic [1:0][31:0] iload;
  logic [1:0]       dREN;
  logic [1:0]       dWEN;
  logic [1:0][31:0] daddr;
  logic [1:0][31:0] dstore;
  logic [1:0]       dwait;
  logic [1:0][31:0] dload;
  logic             ramREN;
  logic             ramWEN;
  logic [31:0]      ramaddr;
  logic [31:0]      ramstore;
  logic [31:0]      ramload;
  logic [1:0]       ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-core I/D cache arbiter onto a single-port RAM
// Dcache beats icache; ties within a class go to the round-robin core; 2-word dcache blocks hold the grant.
module mem_arbiter (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.slave  bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_own_core;
  logic       r_own_d;
  logic       r_rr;
  logic       w_own_core_nxt;
  logic       w_own_d_nxt;
  logic       w_rr_nxt;

  logic [1:0] w_ipend;
  logic [1:0] w_dpend;
  logic [1:0] w_pend_cls;
  logic       w_any;
  logic       w_pick_d;
  logic       w_pick_core;
  logic       w_own_req;
  logic       w_active;
  logic       w_done;
  logic       w_lock;

  assign w_ipend     = bus.iREN;
  assign w_dpend     = bus.dREN | bus.dWEN;
  assign w_any       = (|w_ipend) | (|w_dpend);
  assign w_pick_d    = |w_dpend;
  assign w_pend_cls  = w_pick_d ? w_dpend : w_ipend;
  // With both cores pending the pointer decides, otherwise the lone requester wins.
  assign w_pick_core = (&w_pend_cls) ? r_rr : w_pend_cls[1];

  assign w_own_req = r_own_d ? w_dpend[r_own_core] : w_ipend[r_own_core];
  assign w_active  = (r_state == GRANT) && w_own_req;
  assign w_done    = w_active && (bus.ramstate == RAM_ACCESS);
  // First word of an even-aligned 2-word dcache block keeps the bus for its partner word.
  assign w_lock    = w_done && r_own_d && !bus.daddr[r_own_core][2];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= IDLE;
      r_own_core <= 1'b0;
      r_own_d    <= 1'b0;
      r_rr       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_own_core <= w_own_core_nxt;
      r_own_d    <= w_own_d_nxt;
      r_rr       <= w_rr_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_own_core_nxt = r_own_core;
    w_own_d_nxt    = r_own_d;
    w_rr_nxt       = r_rr;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt    = GRANT;
          w_own_core_nxt = w_pick_core;
          w_own_d_nxt    = w_pick_d;
        end
      end
      GRANT: begin
        if (!w_own_req) begin
          w_state_nxt = IDLE;
        end else if (w_done && !w_lock) begin
          w_state_nxt = IDLE;
          w_rr_nxt    = ~r_own_core;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.iwait    = 2'b11;
    bus.dwait    = 2'b11;
    bus.iload    = '0;
    bus.dload    = '0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = 32'd0;
    bus.ramstore = 32'd0;
    if (w_active) begin
      if (r_own_d) begin
        bus.ramaddr           = bus.daddr[r_own_core];
        bus.ramstore          = bus.dstore[r_own_core];
        bus.ramWEN            = bus.dWEN[r_own_core];
        bus.ramREN            = bus.dREN[r_own_core] & ~bus.dWEN[r_own_core];
        bus.dload[r_own_core] = bus.ramload;
        bus.dwait[r_own_core] = ~w_done;
      end else begin
        bus.ramaddr           = bus.iaddr[r_own_core];
        bus.ramREN            = 1'b1;
        bus.iload[r_own_core] = bus.ramload;
        bus.iwait[r_own_core] = ~w_done;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
// A RAM model answers after 2 BUSY cycles; a monitor logs every cycle and every completion.
module tb_mem_arbiter;

  localparam int LAT  = 2;
  localparam int NLOG = 4096;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          ram_cnt;
  logic        ovr_en;
  logic [31:0] ovr_val;
  logic [3:0]  hit;
  int          words_left [4];
  int          step       [4];

  int          cmp_kind [$];
  int          cmp_cyc  [$];
  logic [31:0] cmp_data [$];

  logic             lg_ren   [NLOG];
  logic             lg_wen   [NLOG];
  logic [31:0]      lg_addr  [NLOG];
  logic [31:0]      lg_store [NLOG];
  logic [1:0]       lg_iwait [NLOG];
  logic [1:0]       lg_dwait [NLOG];
  logic [1:0][31:0] lg_iload [NLOG];
  logic [1:0][31:0] lg_dload [NLOG];

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    ram_cnt = 0;
    ovr_en  = 1'b0;
    ovr_val = 32'd0;
    bus.ramstate = 2'd0;
    bus.ramload  = 32'd0;
    forever begin
      @(negedge CLK);
      if (!nRST) begin
        bus.ramstate = 2'd0;
        ram_cnt = 0;
      end else begin
        if (bus.ramstate == 2'd2) ram_cnt = 0;
        if (bus.ramREN || bus.ramWEN) begin
          if (ram_cnt < LAT) begin
            bus.ramstate = 2'd1;
            ram_cnt++;
          end else begin
            bus.ramstate = 2'd2;
          end
        end else begin
          bus.ramstate = 2'd0;
          ram_cnt = 0;
        end
      end
      bus.ramload = ovr_en ? ovr_val : {bus.ramaddr[15:0] ^ 16'h5A5A, bus.ramaddr[15:0]};
      #2;
      if (cyc < NLOG) begin
        lg_ren[cyc]   = bus.ramREN;
        lg_wen[cyc]   = bus.ramWEN;
        lg_addr[cyc]  = bus.ramaddr;
        lg_store[cyc] = bus.ramstore;
        lg_iwait[cyc] = bus.iwait;
        lg_dwait[cyc] = bus.dwait;
        lg_iload[cyc] = bus.iload;
        lg_dload[cyc] = bus.dload;
      end
      hit = 4'b0000;
      if (nRST) begin
        for (int k = 0; k < 2; k++) begin
          if (!bus.iwait[k]) begin
            cmp_kind.push_back(k); cmp_cyc.push_back(cyc); cmp_data.push_back(bus.iload[k]);
            hit[k] = 1'b1;
          end
          if (!bus.dwait[k]) begin
            cmp_kind.push_back(k + 2); cmp_cyc.push_back(cyc); cmp_data.push_back(bus.dload[k]);
            hit[k + 2] = 1'b1;
          end
        end
      end
      @(posedge CLK);
      #1;
      for (int k = 0; k < 4; k++) begin
        if (hit[k]) begin
          words_left[k]--;
          if (k < 2) begin
            if (words_left[k] <= 0) bus.iREN[k] = 1'b0;
            else bus.iaddr[k] = bus.iaddr[k] + 32'(step[k]);
          end else begin
            if (words_left[k] <= 0) begin
              bus.dREN[k - 2] = 1'b0;
              bus.dWEN[k - 2] = 1'b0;
            end else begin
              bus.daddr[k - 2] = bus.daddr[k - 2] + 32'(step[k]);
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, summary not yet printed");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic req(input int k, input logic [31:0] a, input logic [31:0] d,
                     input logic rd, input logic wr, input int words, input int st);
    words_left[k] = words;
    step[k]       = st;
    if (k < 2) begin
      bus.iaddr[k] = a;
      bus.iREN[k]  = 1'b1;
    end else begin
      bus.daddr[k - 2]  = a;
      bus.dstore[k - 2] = d;
      bus.dREN[k - 2]   = rd;
      bus.dWEN[k - 2]   = wr;
    end
  endtask

  task automatic clear_log();
    cmp_kind.delete();
    cmp_cyc.delete();
    cmp_data.delete();
  endtask

  task automatic wait_cmp(input int n, input int budget, output logic ok);
    int t;
    t = 0;
    while (cmp_kind.size() < n && t < budget) begin
      tick(1);
      t++;
    end
    ok = (cmp_kind.size() >= n);
  endtask

  task automatic test_reset();
    bus.iREN = 2'b11; bus.dREN = 2'b01; bus.dWEN = 2'b00;
    bus.iaddr[0] = 32'h10; bus.iaddr[1] = 32'h20;
    bus.daddr[0] = 32'h30; bus.daddr[1] = 32'h0;
    bus.dstore = '0;
    tick(3);
    n_assert++; if (bus.iwait !== 2'b11) begin n_fail++; $display("FAIL reset_iwait: got %b want 11", bus.iwait); end
    n_assert++; if (bus.dwait !== 2'b11) begin n_fail++; $display("FAIL reset_dwait: got %b want 11", bus.dwait); end
    n_assert++; if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: got REN=%b WEN=%b want 0/0", bus.ramREN, bus.ramWEN); end
    n_assert++; if (bus.ramaddr !== 32'd0) begin n_fail++; $display("FAIL reset_ramaddr: got %h want 0", bus.ramaddr); end
    n_assert++; if (bus.ramstore !== 32'd0) begin n_fail++; $display("FAIL reset_ramstore: got %h want 0", bus.ramstore); end
    n_assert++; if (bus.iload !== '0 || bus.dload !== '0) begin n_fail++; $display("FAIL reset_loads: got i=%h d=%h want 0", bus.iload, bus.dload); end
    bus.iREN = 2'b00; bus.dREN = 2'b00;
    nRST = 1'b1;
    tick(2);
  endtask

  task automatic test_alternate();
    logic ok;
    clear_log();
    req(2, 32'h204, 32'd0, 1'b1, 1'b0, 2, 8);
    req(3, 32'h304, 32'd0, 1'b1, 1'b0, 2, 8);
    wait_cmp(4, 100, ok);
    tick(2);
    n_assert++; if (!ok) begin n_fail++; $display("FAIL alt_timeout: got %0d completions want 4", cmp_kind.size()); end
    if (ok) begin
      n_assert++; if (cmp_kind[0] != 2 || cmp_kind[1] != 3 || cmp_kind[2] != 2 || cmp_kind[3] != 3) begin
        n_fail++; $display("FAIL alt_order: got %0d %0d %0d %0d want 2 3 2 3", cmp_kind[0], cmp_kind[1], cmp_kind[2], cmp_kind[3]); end
      n_assert++; if (cmp_data[0] !== 32'h585E_0204) begin n_fail++; $display("FAIL alt_data0: got %h want 585e0204", cmp_data[0]); end
      n_assert++; if (cmp_data[1] !== 32'h595E_0304) begin n_fail++; $display("FAIL alt_data1: got %h want 595e0304", cmp_data[1]); end
      n_assert++; if (cmp_data[2] !== 32'h5856_020C) begin n_fail++; $display("FAIL alt_data2: got %h want 5856020c", cmp_data[2]); end
      n_assert++; if (cmp_data[3] !== 32'h5956_030C) begin n_fail++; $display("FAIL alt_data3: got %h want 5956030c", cmp_data[3]); end
      n_assert++; if (cmp_cyc[1] - cmp_cyc[0] != 4 || cmp_cyc[3] - cmp_cyc[2] != 4) begin
        n_fail++; $display("FAIL alt_gap: got %0d/%0d want 4/4", cmp_cyc[1] - cmp_cyc[0], cmp_cyc[3] - cmp_cyc[2]); end
      n_assert++; if (lg_dwait[cmp_cyc[0]] !== 2'b10) begin n_fail++; $display("FAIL alt_dwait: got %b want 10", lg_dwait[cmp_cyc[0]]); end
      n_assert++; if (lg_dload[cmp_cyc[0]][1] !== 32'd0) begin n_fail++; $display("FAIL alt_nonowner_load: got %h want 0", lg_dload[cmp_cyc[0]][1]); end
    end
  endtask

  task automatic test_single_read();
    logic ok;
    int   t0;
    int   c;
    clear_log();
    ovr_en = 1'b1; ovr_val = 32'hDEAD_BEEF;
    t0 = cyc;
    req(0, 32'h40, 32'd0, 1'b1, 1'b0, 1, 0);
    wait_cmp(1, 50, ok);
    tick(3);
    ovr_en = 1'b0;
    n_assert++; if (!ok) begin n_fail++; $display("FAIL i0_timeout: got %0d completions want 1", cmp_kind.size()); end
    if (ok) begin
      c = cmp_cyc[0];
      n_assert++; if (cmp_kind[0] != 0) begin n_fail++; $display("FAIL i0_kind: got %0d want 0", cmp_kind[0]); end
      n_assert++; if (cmp_data[0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL i0_data: got %h want deadbeef", cmp_data[0]); end
      n_assert++; if (c != t0 + 3) begin n_fail++; $display("FAIL i0_latency: got cycle %0d want %0d", c, t0 + 3); end
      n_assert++; if (lg_iwait[c] !== 2'b10 || lg_iwait[c - 1] !== 2'b11 || lg_iwait[c + 1] !== 2'b11) begin
        n_fail++; $display("FAIL i0_iwait_pulse: got %b,%b,%b want 11,10,11", lg_iwait[c - 1], lg_iwait[c], lg_iwait[c + 1]); end
      n_assert++; if (lg_ren[c] !== 1'b1 || lg_addr[c] !== 32'h40) begin n_fail++; $display("FAIL i0_strobe: got REN=%b addr=%h want 1/40", lg_ren[c], lg_addr[c]); end
      n_assert++; if (lg_ren[c + 1] !== 1'b0) begin n_fail++; $display("FAIL i0_ren_drop: got %b want 0", lg_ren[c + 1]); end
      n_assert++; if (lg_iload[c][1] !== 32'd0) begin n_fail++; $display("FAIL i0_iload1: got %h want 0", lg_iload[c][1]); end
    end
  endtask

  task automatic test_priority();
    logic ok;
    int   c;
    clear_log();
    req(0, 32'h80, 32'd0, 1'b1, 1'b0, 1, 0);
    req(2, 32'hA4, 32'd0, 1'b1, 1'b0, 1, 0);
    wait_cmp(2, 60, ok);
    tick(2);
    n_assert++; if (!ok) begin n_fail++; $display("FAIL prio_timeout: got %0d completions want 2", cmp_kind.size()); end
    if (ok) begin
      c = cmp_cyc[0];
      n_assert++; if (cmp_kind[0] != 2 || cmp_kind[1] != 0) begin n_fail++; $display("FAIL prio_order: got %0d %0d want 2 0", cmp_kind[0], cmp_kind[1]); end
      n_assert++; if (cmp_data[0] !== 32'h5AFE_00A4 || cmp_data[1] !== 32'h5ADA_0080) begin
        n_fail++; $display("FAIL prio_data: got %h %h want 5afe00a4 5ada0080", cmp_data[0], cmp_data[1]); end
      n_assert++; if (lg_ren[c + 1] !== 1'b0 || lg_ren[c + 2] !== 1'b1 || lg_addr[c + 2] !== 32'h80) begin
        n_fail++; $display("FAIL prio_idle_gap: got REN %b,%b addr %h want 0,1 addr 80", lg_ren[c + 1], lg_ren[c + 2], lg_addr[c + 2]); end
      n_assert++; if (lg_iwait[c] !== 2'b11) begin n_fail++; $display("FAIL prio_iwait_held: got %b want 11", lg_iwait[c]); end
    end
  endtask

  task automatic test_burst_lock();
    logic ok;
    int   c;
    clear_log();
    req(3, 32'h100, 32'h1111_0001, 1'b0, 1'b1, 2, 4);
    tick(1);
    req(2, 32'h208, 32'd0, 1'b1, 1'b0, 1, 0);
    wait_cmp(3, 80, ok);
    tick(2);
    n_assert++; if (!ok) begin n_fail++; $display("FAIL lock_timeout: got %0d completions want 3", cmp_kind.size()); end
    if (ok) begin
      c = cmp_cyc[0];
      n_assert++; if (cmp_kind[0] != 3 || cmp_kind[1] != 3 || cmp_kind[2] != 2) begin
        n_fail++; $display("FAIL lock_order: got %0d %0d %0d want 3 3 2", cmp_kind[0], cmp_kind[1], cmp_kind[2]); end
      n_assert++; if (cmp_cyc[1] - c != 3) begin n_fail++; $display("FAIL lock_no_idle: got gap %0d want 3", cmp_cyc[1] - c); end
      n_assert++; if (lg_wen[c + 1] !== 1'b1 || lg_addr[c + 1] !== 32'h104) begin
        n_fail++; $display("FAIL lock_second_word: got WEN=%b addr=%h want 1/104", lg_wen[c + 1], lg_addr[c + 1]); end
      n_assert++; if (lg_ren[c] !== 1'b0 || lg_wen[c] !== 1'b1 || lg_store[c] !== 32'h1111_0001) begin
        n_fail++; $display("FAIL lock_write: got REN=%b WEN=%b store=%h want 0/1/11110001", lg_ren[c], lg_wen[c], lg_store[c]); end
      n_assert++; if (cmp_cyc[2] - cmp_cyc[1] != 4) begin n_fail++; $display("FAIL lock_release_gap: got %0d want 4", cmp_cyc[2] - cmp_cyc[1]); end
    end
  endtask

  task automatic test_read_write();
    logic ok;
    int   c;
    clear_log();
    req(2, 32'h304, 32'hCAFE_F00D, 1'b1, 1'b1, 1, 0);
    wait_cmp(1, 50, ok);
    tick(2);
    n_assert++; if (!ok) begin n_fail++; $display("FAIL rw_timeout: got %0d completions want 1", cmp_kind.size()); end
    if (ok) begin
      c = cmp_cyc[0];
      n_assert++; if (lg_wen[c] !== 1'b1 || lg_ren[c] !== 1'b0) begin n_fail++; $display("FAIL rw_strobes: got WEN=%b REN=%b want 1/0", lg_wen[c], lg_ren[c]); end
      n_assert++; if (lg_store[c] !== 32'hCAFE_F00D || lg_addr[c] !== 32'h304) begin
        n_fail++; $display("FAIL rw_bus: got store=%h addr=%h want cafef00d/304", lg_store[c], lg_addr[c]); end
      n_assert++; if (lg_wen[c - 2] !== 1'b1 || lg_dwait[c - 1] !== 2'b11) begin
        n_fail++; $display("FAIL rw_busy_hold: got WEN=%b dwait=%b want 1/11", lg_wen[c - 2], lg_dwait[c - 1]); end
    end
  endtask

  task automatic test_reset_mid();
    logic ok;
    clear_log();
    req(3, 32'h400, 32'h0000_7777, 1'b0, 1'b1, 1, 0);
    tick(2);
    n_assert++; if (bus.ramWEN !== 1'b1 || bus.ramstate !== 2'd1) begin
      n_fail++; $display("FAIL rst_pre_busy: got WEN=%b state=%0d want 1/1", bus.ramWEN, bus.ramstate); end
    nRST = 1'b0;
    #1;
    n_assert++; if (bus.ramWEN !== 1'b0 || bus.ramREN !== 1'b0) begin n_fail++; $display("FAIL rst_strobes: got WEN=%b REN=%b want 0/0", bus.ramWEN, bus.ramREN); end
    n_assert++; if (bus.dwait !== 2'b11 || bus.ramaddr !== 32'd0) begin n_fail++; $display("FAIL rst_dwait: got %b addr=%h want 11/0", bus.dwait, bus.ramaddr); end
    bus.dWEN[1] = 1'b0;
    words_left[3] = 0;
    req(1, 32'h600, 32'd0, 1'b1, 1'b0, 1, 0);
    req(0, 32'h500, 32'd0, 1'b1, 1'b0, 1, 0);
    tick(2);
    nRST = 1'b1;
    wait_cmp(2, 60, ok);
    tick(3);
    n_assert++; if (!ok || cmp_kind.size() != 2) begin n_fail++; $display("FAIL rst_completions: got %0d want 2", cmp_kind.size()); end
    if (ok) begin
      n_assert++; if (cmp_kind[0] != 0 || cmp_kind[1] != 1) begin n_fail++; $display("FAIL rst_rr_order: got %0d %0d want 0 1", cmp_kind[0], cmp_kind[1]); end
    end
  endtask

  initial begin
    bus.iREN = 2'b00; bus.dREN = 2'b00; bus.dWEN = 2'b00;
    bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
    for (int k = 0; k < 4; k++) begin
      words_left[k] = 0;
      step[k] = 0;
    end
    test_reset();
    test_alternate();
    test_single_read();
    test_priority();
    test_burst_lock();
    test_read_write();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
